// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, one-cycle-latency imem requests, 2-entry {pc, inst}
// output buffer with valid/ready, redirect flush and a sticky misalignment fault.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        fault
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;

   typedef enum logic {
      MODE_RUN   = 1'b0,
      MODE_FAULT = 1'b1
   } mode_e;

   mode_e             mode_q, mode_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   fifo_pc_q   [DEPTH];
   logic [XLEN-1:0]   fifo_pc_d   [DEPTH];
   logic [XLEN-1:0]   fifo_inst_q [DEPTH];
   logic [XLEN-1:0]   fifo_inst_d [DEPTH];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              inflight_q, inflight_d;
   logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
   logic              kill_q, kill_d;

   logic              pop;
   logic              push;
   logic [2:0]        occ;

   // Next-state and output decode
   always_comb begin
      mode_d        = mode_q;
      pc_d          = pc_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_inst_d   = fifo_inst_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      kill_d        = 1'b0;
      imem_req      = 1'b0;
      imem_addr     = pc_q;
      out_valid     = 1'b0;
      out_pc        = fifo_pc_q[rd_ptr_q];
      out_inst      = fifo_inst_q[rd_ptr_q];
      fault         = (mode_q == MODE_FAULT);
      pop           = 1'b0;
      push          = inflight_q & ~kill_q;
      occ           = {1'b0, count_q} + 3'(inflight_q);

      case (mode_q)
         MODE_RUN: begin
            out_valid = (count_q != 2'd0) & ~redirect;
            pop       = out_valid & out_ready;
            if (redirect) begin
               count_d  = 2'd0;
               rd_ptr_d = 1'b0;
               wr_ptr_d = 1'b0;
               if (redirect_pc[1:0] == 2'b00) begin
                  pc_d   = redirect_pc;
                  kill_d = inflight_q;
               end else begin
                  mode_d = MODE_FAULT;
               end
            end else begin
               // Issue only when the buffer can absorb this request, counting this cycle's pop
               if (~rst && (occ < 3'd2 + 3'(pop))) begin
                  imem_req      = 1'b1;
                  pc_d          = pc_q + 32'd4;
                  inflight_d    = 1'b1;
                  inflight_pc_d = pc_q;
               end
               if (push) begin
                  fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
                  fifo_inst_d[wr_ptr_q] = imem_rdata;
                  wr_ptr_d              = ~wr_ptr_q;
               end
               if (pop) begin
                  rd_ptr_d = ~rd_ptr_q;
               end
               count_d = count_q + 2'(push) - 2'(pop);
            end
         end
         MODE_FAULT: begin
            count_d = 2'd0;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q        <= MODE_RUN;
         pc_q          <= RESET_PC;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_inst_q[i] <= '0;
         end
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         kill_q        <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         pc_q          <= pc_d;
         fifo_pc_q     <= fifo_pc_d;
         fifo_inst_q   <= fifo_inst_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         kill_q        <= kill_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: memory returns word addr>>2; expected pcs queued by
// the stimulus, consumed by a negedge monitor on every accepted transfer.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'hDEAD_BEEF;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        fault;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q [$];

   inst_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   // Synchronous memory: word i lives at byte address 4i
   always @(posedge clk)
      imem_rdata <= imem_req ? {2'b00, imem_addr[31:2]} : 32'hDEAD_BEEF;

   // Monitor: every accepted transfer must match the head of the expected queue
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         logic [31:0] e;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h, required no transfer", out_pc, out_inst);
         end else begin
            e = exp_q.pop_front();
            if (out_pc !== e || out_inst !== {2'b00, e[31:2]}) begin
               n_fail++;
               $display("FAIL sb_transfer: got pc=%h inst=%h, required pc=%h inst=%h",
                        out_pc, out_inst, e, {2'b00, e[31:2]});
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      logic [31:0] a;
      a = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(a);
         a = a + 32'd4;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h100);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_inst", out_inst, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_fault", 32'(fault), 32'd0);

      // Reset release, then backpressure on cycles 3..8
      push_seq(32'h100, 40);
      next_cyc(); rst = 1'b0; out_ready = 1'b1; #1;
      chk("c0_req", 32'(imem_req), 32'd1);
      chk("c0_addr", imem_addr, 32'h100);
      chk("c0_valid", 32'(out_valid), 32'd0);
      next_cyc(); #1;
      chk("c1_valid", 32'(out_valid), 32'd0);
      chk("c1_addr", imem_addr, 32'h104);
      next_cyc(); #1;
      chk("c2_valid", 32'(out_valid), 32'd1);
      chk("c2_pc", out_pc, 32'h100);
      next_cyc(); out_ready = 1'b0; #1;
      chk("c3_req_stop", 32'(imem_req), 32'd0);
      for (int c = 4; c <= 8; c++) begin
         next_cyc(); #1;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_pc_stable", out_pc, 32'h104);
         chk("bp_req", 32'(imem_req), 32'd0);
      end
      next_cyc(); out_ready = 1'b1; #1;
      chk("c9_req", 32'(imem_req), 32'd1);
      chk("c9_addr", imem_addr, 32'h10C);
      chk("c9_pc", out_pc, 32'h104);
      for (int c = 10; c <= 14; c++) begin
         next_cyc(); #1;
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_pc", out_pc, 32'h104 + 32'(4 * (c - 9)));
      end

      // Redirect to 0x40 during full-rate streaming with data in flight
      next_cyc(); redirect = 1'b1; redirect_pc = 32'h40;
      exp_q.delete(); push_seq(32'h40, 20); #1;
      chk("rd_t_valid", 32'(out_valid), 32'd0);
      chk("rd_t_req", 32'(imem_req), 32'd0);
      next_cyc(); redirect = 1'b0; #1;
      chk("rd_t1_req", 32'(imem_req), 32'd1);
      chk("rd_t1_addr", imem_addr, 32'h40);
      chk("rd_t1_valid", 32'(out_valid), 32'd0);
      next_cyc(); #1;
      chk("rd_t2_valid", 32'(out_valid), 32'd0);
      next_cyc(); #1;
      chk("rd_t3_valid", 32'(out_valid), 32'd1);
      chk("rd_t3_pc", out_pc, 32'h40);
      repeat (4) next_cyc();

      // Fill buffer, then redirect near the top of memory to check wrap
      out_ready = 1'b0;
      repeat (3) next_cyc();
      next_cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      exp_q.delete(); push_seq(32'hFFFF_FFF8, 20); #1;
      chk("wr_t_valid", 32'(out_valid), 32'd0);
      next_cyc(); redirect = 1'b0; out_ready = 1'b1; #1;
      chk("wr_t1_addr", imem_addr, 32'hFFFF_FFF8);
      next_cyc(); #1;
      chk("wr_t2_addr", imem_addr, 32'hFFFF_FFFC);
      next_cyc(); #1;
      chk("wr_t3_pc", out_pc, 32'hFFFF_FFF8);
      chk("wr_t3_addr", imem_addr, 32'h0);
      next_cyc(); #1;
      chk("wr_t4_pc", out_pc, 32'hFFFF_FFFC);
      next_cyc(); #1;
      chk("wr_t5_pc", out_pc, 32'h0);
      next_cyc();

      // Misaligned redirect enters sticky fault; later redirect ignored
      next_cyc(); redirect = 1'b1; redirect_pc = 32'h42; exp_q.delete(); #1;
      chk("mis_t_valid", 32'(out_valid), 32'd0);
      chk("mis_t_req", 32'(imem_req), 32'd0);
      next_cyc(); redirect = 1'b0; #1;
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_req", 32'(imem_req), 32'd0);
      chk("mis_valid", 32'(out_valid), 32'd0);
      repeat (3) next_cyc();
      next_cyc(); redirect = 1'b1; redirect_pc = 32'h80; #1;
      chk("flt_redir_req", 32'(imem_req), 32'd0);
      for (int c = 0; c < 4; c++) begin
         next_cyc(); redirect = 1'b0; #1;
         chk("flt_fault", 32'(fault), 32'd1);
         chk("flt_valid", 32'(out_valid), 32'd0);
         chk("flt_req", 32'(imem_req), 32'd0);
      end

      // Reset clears the fault
      next_cyc(); rst = 1'b1; out_ready = 1'b0; #1;
      chk("rst2_req", 32'(imem_req), 32'd0);
      next_cyc(); #1;
      chk("rst2_fault", 32'(fault), 32'd0);
      chk("rst2_valid", 32'(out_valid), 32'd0);
      chk("rst2_addr", imem_addr, 32'h100);
      chk("rst2_pc", out_pc, 32'h0);
      push_seq(32'h100, 40);
      next_cyc(); rst = 1'b0; out_ready = 1'b1; #1;
      chk("r2c0_req", 32'(imem_req), 32'd1);
      chk("r2c0_addr", imem_addr, 32'h100);

      // Stream with toggling ready, then pulse reset mid-stream
      for (int c = 1; c <= 12; c++) begin
         next_cyc(); out_ready = ((c % 3) != 0);
      end
      next_cyc(); rst = 1'b1; out_ready = 1'b0; exp_q.delete();
      push_seq(32'h100, 40);
      next_cyc(); rst = 1'b0; out_ready = 1'b1; #1;
      chk("r3c0_addr", imem_addr, 32'h100);
      chk("r3c0_valid", 32'(out_valid), 32'd0);
      next_cyc(); #1;
      chk("r3c1_valid", 32'(out_valid), 32'd0);
      next_cyc(); #1;
      chk("r3c2_valid", 32'(out_valid), 32'd1);
      chk("r3c2_pc", out_pc, 32'h100);
      repeat (5) next_cyc();
      out_ready = 1'b0;
      repeat (2) next_cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
